// File: rtl/espnet_col_pkg.sv
// Shared types and constants for the ESPNet column load scheduler.
// Slot count, arbiter control codes, state encoding.
package espnet_col_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int COL_ADDR_WIDTH_DEF = 2560;

   localparam logic [2:0] CTRL_HOLD = 3'd0;
   localparam logic [2:0] LOAD_S0 = 3'd1;
   localparam logic [2:0] LOAD_S1 = 3'd2;
   localparam logic [2:0] LOAD_S2 = 3'd3;
   localparam logic [2:0] LOAD_S3 = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   function automatic logic [2:0] load_code(input logic [1:0] slot);
      return 3'(slot) + 3'd1;
   endfunction
endpackage

// File: rtl/col_load_sched_rr_free_pick.sv
// Round-robin first-free slot picker over the four arbiter slots.
// Searches upward from rr, wrapping 3 -> 0.
module rr_free_pick
   import espnet_col_pkg::*;
(
   input  logic [3:0] occ,
   input  logic [1:0] rr,
   output logic [1:0] slot,
   output logic       any_free
);
   always_comb begin
      logic [1:0] idx;
      idx = '0;
      slot = rr;
      any_free = 1'b0;
      // Walk from the farthest candidate back so the nearest free slot wins.
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         idx = rr + 2'(k);
         if (!occ[idx]) begin
            slot = idx;
            any_free = 1'b1;
         end
      end
   end
endmodule

// File: rtl/col_load_sched.sv
// Column load scheduler feeding col_arbiter slots from the line fetcher.
// Optional COL_LOAD_SCHED_PERF_EN adds the stall_cycles counter.
module col_load_sched
   import espnet_col_pkg::*;
#(
   parameter int COL_ADDR_WIDTH = COL_ADDR_WIDTH_DEF,
   parameter int FRAME_COLS = 128
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [COL_ADDR_WIDTH-1:0] in_addr,
   input  logic [3:0]                slot_release,
   output logic [2:0]                control,
   output logic [COL_ADDR_WIDTH-1:0] col_addr_out,
   output logic [3:0]                slot_valid,
   output logic                      busy,
   output logic                      frame_done
`ifdef COL_LOAD_SCHED_PERF_EN
   , output logic [31:0]             stall_cycles
`endif
);
   localparam logic [15:0] LAST = 16'(FRAME_COLS);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  occ;
   logic [1:0]  rr;
   logic [15:0] col_cnt;
   logic [1:0]  pick;
   logic        any_free;
   logic        accept;
   logic        last_col;
   logic        start_ok;
   logic [3:0]  load_oh;
   logic [3:0]  pend_oh;

   rr_free_pick u_pick (
      .occ      (occ),
      .rr       (rr),
      .slot     (pick),
      .any_free (any_free)
   );

   assign in_ready = (state == RUN) && any_free && (col_cnt < LAST);
   assign accept   = in_valid && in_ready;
   assign last_col = (col_cnt + 16'd1) == LAST;
   assign start_ok = (state == IDLE) && start;
   assign busy     = state != IDLE;
   assign load_oh  = accept ? (4'b0001 << pick) : 4'b0000;

   // Slot written to the arbiter last cycle becomes valid this edge.
   always_comb begin
      pend_oh = 4'b0000;
      unique case (control)
         LOAD_S0: pend_oh = 4'b0001;
         LOAD_S1: pend_oh = 4'b0010;
         LOAD_S2: pend_oh = 4'b0100;
         LOAD_S3: pend_oh = 4'b1000;
         default: pend_oh = 4'b0000;
      endcase
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (accept && last_col) state_nxt = DRAIN;
         DRAIN:   if (occ == 4'b0000) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         control      <= CTRL_HOLD;
         col_addr_out <= '0;
         occ          <= '0;
         slot_valid   <= '0;
         frame_done   <= 1'b0;
         rr           <= '0;
         col_cnt      <= '0;
      end else begin
         control    <= accept ? load_code(pick) : CTRL_HOLD;
         if (accept) col_addr_out <= in_addr;
         occ        <= (occ & ~slot_release) | load_oh;
         slot_valid <= (slot_valid | pend_oh) & ~slot_release;
         frame_done <= (state == DRAIN) && (occ == 4'b0000);
         if (start_ok) begin
            col_cnt <= '0;
            rr      <= '0;
         end else if (accept) begin
            col_cnt <= col_cnt + 16'd1;
            rr      <= pick + 2'd1;
         end
      end
   end

`ifdef COL_LOAD_SCHED_PERF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (start_ok) begin
         stall_cycles <= '0;
      end else if ((state == RUN) && in_valid && !in_ready
                   && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_col_load_sched.sv
// Self-checking bench for col_load_sched: vector table, corner sequences,
// and random traffic against a slot-level reference model.
module tb_col_load_sched;
   localparam int W  = 64;
   localparam int FC = 6;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_addr = '0;
   logic [3:0]   slot_release = '0;
   logic [2:0]   control;
   logic [W-1:0] col_addr_out;
   logic [3:0]   slot_valid;
   logic         busy;
   logic         frame_done;
`ifdef COL_LOAD_SCHED_PERF_EN
   logic [31:0]  stall_cycles;
`endif

   always #5 clock = ~clock;

   col_load_sched #(
      .COL_ADDR_WIDTH (W),
      .FRAME_COLS     (FC)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .slot_release (slot_release),
      .control      (control),
      .col_addr_out (col_addr_out),
      .slot_valid   (slot_valid),
      .busy         (busy),
      .frame_done   (frame_done)
`ifdef COL_LOAD_SCHED_PERF_EN
      , .stall_cycles (stall_cycles)
`endif
   );

   int pass_cnt = 0;
   int total = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Reference model: per-slot flags, phase 0 idle / 1 run / 2 drain.
   int           mst;
   bit           mocc[4];
   bit           mval[4];
   int           mrr;
   int           mcnt;
   int           mctrl;
   logic [W-1:0] maddr;
   bit           mdone;
   longint       mstall;

   task automatic mreset();
      mst = 0; mrr = 0; mcnt = 0; mctrl = 0; maddr = '0;
      mdone = 0; mstall = 0;
      for (int i = 0; i < 4; i++) begin
         mocc[i] = 0;
         mval[i] = 0;
      end
   endtask

   function automatic int m_pick();
      for (int k = 0; k < 4; k++)
         if (!mocc[(mrr + k) % 4]) return (mrr + k) % 4;
      return -1;
   endfunction

   function automatic bit m_ready();
      return (mst == 1) && (m_pick() >= 0) && (mcnt < FC);
   endfunction

   task automatic m_compare();
      logic [3:0] sv;
      for (int i = 0; i < 4; i++) sv[i] = mval[i];
      chk("control", 64'(control), 64'(mctrl));
      chk("col_addr_out", 64'(col_addr_out), 64'(maddr));
      chk("slot_valid", 64'(slot_valid), 64'(sv));
      chk("busy", 64'(busy), 64'(mst != 0));
      chk("frame_done", 64'(frame_done), 64'(mdone));
`ifdef COL_LOAD_SCHED_PERF_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(mstall));
`endif
   endtask

   task automatic cyc(input bit st, input bit iv, input logic [W-1:0] a,
                      input logic [3:0] rel, output bit rdy_seen);
      bit rdy;
      bit acc;
      bit any_occ;
      int s;
      bit nv[4];
      bit no[4];
      start = st; in_valid = iv; in_addr = a; slot_release = rel;
      #1;
      rdy = m_ready();
      rdy_seen = in_ready;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      acc = rdy && iv;
      s = m_pick();
      any_occ = 0;
      for (int i = 0; i < 4; i++) begin
         any_occ |= mocc[i];
         nv[i] = (mval[i] || (mctrl == i + 1)) && !rel[i];
         no[i] = (mocc[i] && !rel[i]) || (acc && s == i);
      end
      @(posedge clock);
      #1;
      mdone = 0;
      case (mst)
         0: if (st) begin
            mst = 1; mcnt = 0; mrr = 0; mstall = 0;
         end
         1: begin
            if (iv && !rdy && mstall < 64'hFFFF_FFFF) mstall++;
            if (acc) begin
               mcnt++;
               mrr = (s + 1) % 4;
               if (mcnt == FC) mst = 2;
            end
         end
         default: if (!any_occ) begin
            mst = 0; mdone = 1;
         end
      endcase
      mctrl = acc ? s + 1 : 0;
      if (acc) maddr = a;
      for (int i = 0; i < 4; i++) begin
         mval[i] = nv[i];
         mocc[i] = no[i];
      end
      m_compare();
   endtask

   typedef struct {
      bit           st;
      bit           iv;
      logic [W-1:0] a;
      logic [3:0]   rel;
      bit           e_rdy;
      logic [2:0]   e_ctrl;
      logic [3:0]   e_sv;
      bit           e_busy;
      bit           e_done;
   } vec_t;

   vec_t tbl[14];

   initial begin
      bit rs;
      bit got;
      tbl[0]  = '{1, 0, 64'h0, 4'b0000, 0, 3'd0, 4'b0000, 1, 0};
      tbl[1]  = '{0, 1, 64'hA, 4'b0000, 1, 3'd1, 4'b0000, 1, 0};
      tbl[2]  = '{0, 1, 64'hB, 4'b0000, 1, 3'd2, 4'b0001, 1, 0};
      tbl[3]  = '{0, 1, 64'hC, 4'b0000, 1, 3'd3, 4'b0011, 1, 0};
      tbl[4]  = '{0, 1, 64'hD, 4'b0000, 1, 3'd4, 4'b0111, 1, 0};
      tbl[5]  = '{0, 1, 64'hE, 4'b0000, 0, 3'd0, 4'b1111, 1, 0};
      tbl[6]  = '{0, 1, 64'hE, 4'b0100, 0, 3'd0, 4'b1011, 1, 0};
      tbl[7]  = '{0, 1, 64'hE, 4'b0000, 1, 3'd3, 4'b1011, 1, 0};
      tbl[8]  = '{0, 0, 64'h0, 4'b0000, 0, 3'd0, 4'b1111, 1, 0};
      tbl[9]  = '{0, 1, 64'hF, 4'b0001, 0, 3'd0, 4'b1110, 1, 0};
      tbl[10] = '{0, 1, 64'hF, 4'b0000, 1, 3'd1, 4'b1110, 1, 0};
      tbl[11] = '{0, 1, 64'h9, 4'b1111, 0, 3'd0, 4'b0000, 1, 0};
      tbl[12] = '{0, 0, 64'h0, 4'b0000, 0, 3'd0, 4'b0000, 0, 1};
      tbl[13] = '{0, 0, 64'h0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0};

      mreset();
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_control", 64'(control), 64'h0);
      chk("rst_addr", 64'(col_addr_out), 64'h0);
      chk("rst_slot_valid", 64'(slot_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_frame_done", 64'(frame_done), 64'h0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].st, tbl[i].iv, tbl[i].a, tbl[i].rel, rs);
         chk($sformatf("tbl%0d_ready", i), 64'(rs), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_ctrl", i), 64'(control), 64'(tbl[i].e_ctrl));
         chk($sformatf("tbl%0d_sv", i), 64'(slot_valid), 64'(tbl[i].e_sv));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_done", i), 64'(frame_done), 64'(tbl[i].e_done));
      end

      // rr lands on 1 with only slot 1 held: next word goes to slot 2.
      cyc(1, 0, 0, 4'b0000, rs);
      cyc(0, 1, 64'h21, 4'b0000, rs);
      cyc(0, 1, 64'h22, 4'b0000, rs);
      cyc(0, 1, 64'h23, 4'b0000, rs);
      cyc(0, 1, 64'h24, 4'b0000, rs);
      cyc(0, 0, 0, 4'b0000, rs);
      cyc(0, 0, 0, 4'b1101, rs);
      cyc(0, 1, 64'h25, 4'b0000, rs);
      chk("rr_first_ctrl", 64'(control), 64'd1);
      cyc(0, 0, 0, 4'b0000, rs);
      cyc(0, 0, 0, 4'b0001, rs);
      cyc(0, 1, 64'h26, 4'b0000, rs);
      chk("rr_skip_ctrl", 64'(control), 64'd3);
      chk("rr_skip_addr", 64'(col_addr_out), 64'h26);
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         cyc(0, 0, 0, 4'b1111, rs);
         got = frame_done;
      end
      chk("rr_frame_done_seen", 64'(got), 64'd1);

      // Abort mid-frame with three slots occupied.
      cyc(1, 0, 0, 4'b0000, rs);
      cyc(0, 1, 64'h31, 4'b0000, rs);
      cyc(0, 1, 64'h32, 4'b0000, rs);
      cyc(0, 1, 64'h33, 4'b0000, rs);
      cyc(0, 0, 0, 4'b0000, rs);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_control", 64'(control), 64'h0);
      chk("abort_addr", 64'(col_addr_out), 64'h0);
      chk("abort_slot_valid", 64'(slot_valid), 64'h0);
      chk("abort_in_ready", 64'(in_ready), 64'h0);
      chk("abort_busy", 64'(busy), 64'h0);
      mreset();
      @(posedge clock);
      #1;
      chk("abort_frame_done", 64'(frame_done), 64'h0);
      reset = 1'b1;

      // Clean frame after abort, then five cycles against full slots.
      cyc(1, 0, 0, 4'b0000, rs);
      cyc(0, 1, 64'h41, 4'b0000, rs);
      chk("restart_ctrl", 64'(control), 64'd1);
      cyc(0, 1, 64'h42, 4'b0000, rs);
      cyc(0, 1, 64'h43, 4'b0000, rs);
      cyc(0, 1, 64'h44, 4'b0000, rs);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 64'h45, 4'b0000, rs);
         chk("full_in_ready", 64'(rs), 64'd0);
      end
`ifdef COL_LOAD_SCHED_PERF_EN
      chk("stall_five", 64'(stall_cycles), 64'd5);
`endif

      for (int n = 0; n < 3000; n++) begin
         bit st;
         bit iv;
         st = (mst == 0) ? ($urandom_range(0, 3) == 0)
                         : ($urandom_range(0, 15) == 0);
         iv = $urandom_range(0, 3) != 0;
         cyc(st, iv, {$urandom, $urandom},
             4'($urandom) & 4'($urandom), rs);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
